// File: rtl/xor_gate.sv
// Bitwise XOR with registered copy, parity and optional Hamming accumulator (XOR_STATS_EN).
// Latency: z combinational; z_q/par_q/vld_q/dist_q one clk after an en=1 edge.
// Backpressure: none; en is a capture strobe and vld_q simply echoes it.
module xor_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] z_q,
    output logic             par_q,
    output logic             vld_q
`ifdef XOR_STATS_EN
    ,
    output logic [CNT_W-1:0] dist_q
`endif
);

    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("xor_gate: WIDTH and CNT_W must both be >= 1");
    end

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] z_d;
    logic             par_d;
    logic             vld_d;

    assign diff = a ^ b;
    assign z    = diff;

    always_comb begin
        z_d   = z_q;
        par_d = par_q;
        vld_d = en;
        if (en) begin
            z_d   = diff;
            par_d = ^diff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q   <= '0;
            par_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            z_q   <= z_d;
            par_q <= par_d;
            vld_q <= vld_d;
        end
    end

`ifdef XOR_STATS_EN
    localparam int PC_W  = $clog2(WIDTH + 1);
    // One spare bit so the pre-saturation sum can never wrap.
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    logic [PC_W-1:0]  pop;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] dist_d;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PC_W'(diff[i]);
        end
        sum    = SUM_W'(dist_q) + SUM_W'(pop);
        dist_d = dist_q;
        if (en) begin
            if (sum > SUM_W'({CNT_W{1'b1}})) begin
                dist_d = '1;
            end else begin
                dist_d = sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dist_q <= '0;
        end else begin
            dist_q <= dist_d;
        end
    end
`endif

endmodule

// File: tb/tb_xor_gate.sv
// Bench for xor_gate: 1-bit and 8-bit instances against an arithmetic model plus literal spot checks.
module tb_xor_gate;

    localparam int CNT_W8 = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [0:0] a1, b1;
    logic [7:0] a8, b8;

    logic [0:0] z1, z1_q;
    logic       par1_q, vld1_q;
    logic [7:0] z8, z8_q;
    logic       par8_q, vld8_q;
`ifdef XOR_STATS_EN
    logic [15:0]       dist1_q;
    logic [CNT_W8-1:0] dist8_q;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    xor_gate #(.WIDTH(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .en(en),
        .z(z1), .z_q(z1_q), .par_q(par1_q), .vld_q(vld1_q)
`ifdef XOR_STATS_EN
        , .dist_q(dist1_q)
`endif
    );

    xor_gate #(.WIDTH(8), .CNT_W(CNT_W8)) u8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .en(en),
        .z(z8), .z_q(z8_q), .par_q(par8_q), .vld_q(vld8_q)
`ifdef XOR_STATS_EN
        , .dist_q(dist8_q)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: what the registered outputs must hold after each edge.
    int exp_z1, exp_par1, exp_vld, exp_z8, exp_par8, exp_d1, exp_d8;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_z1 <= 0; exp_par1 <= 0; exp_vld <= 0;
            exp_z8 <= 0; exp_par8 <= 0; exp_d1 <= 0; exp_d8 <= 0;
        end else begin
            exp_vld <= int'(en);
            if (en) begin
                exp_z1   <= int'(a1 ^ b1);
                exp_par1 <= $countones(a1 ^ b1) % 2;
                exp_z8   <= int'(a8 ^ b8);
                exp_par8 <= $countones(a8 ^ b8) % 2;
                exp_d1   <= (exp_d1 + $countones(a1 ^ b1) > 65535) ? 65535
                                                                  : exp_d1 + $countones(a1 ^ b1);
                exp_d8   <= (exp_d8 + $countones(a8 ^ b8) > (1 << CNT_W8) - 1) ? (1 << CNT_W8) - 1
                                                                               : exp_d8 + $countones(a8 ^ b8);
            end
        end
    end

    always begin
        @(posedge clk);
        #2;
        check("z1_q",   32'(z1_q),   32'(exp_z1));
        check("par1_q", 32'(par1_q), 32'(exp_par1));
        check("vld1_q", 32'(vld1_q), 32'(exp_vld));
        check("z8_q",   32'(z8_q),   32'(exp_z8));
        check("par8_q", 32'(par8_q), 32'(exp_par8));
        check("vld8_q", 32'(vld8_q), 32'(exp_vld));
`ifdef XOR_STATS_EN
        check("dist1_q", 32'(dist1_q), 32'(exp_d1));
        check("dist8_q", 32'(dist8_q), 32'(exp_d8));
`endif
    end

    task automatic check_regs_zero(input string tag);
        check({tag, "_z1_q"},  32'(z1_q),   32'h0);
        check({tag, "_par1"},  32'(par1_q), 32'h0);
        check({tag, "_vld1"},  32'(vld1_q), 32'h0);
        check({tag, "_z8_q"},  32'(z8_q),   32'h0);
        check({tag, "_par8"},  32'(par8_q), 32'h0);
        check({tag, "_vld8"},  32'(vld8_q), 32'h0);
`ifdef XOR_STATS_EN
        check({tag, "_dist8"}, 32'(dist8_q), 32'h0);
`endif
    endtask

    logic [1:0] ab;

    initial begin
        rst_n = 1'b0; en = 1'b0; a1 = '0; b1 = '0; a8 = '0; b8 = '0;
        #1;
        check_regs_zero("reset");

        // 1-bit truth table while held in reset, with the clock running.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a1 = ab[1]; b1 = ab[0];
            #1;
            check("tt_rst_z", 32'(z1), (i == 1 || i == 2) ? 32'h1 : 32'h0);
            #9;
        end
        rst_n = 1'b1;

        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a1 = ab[1]; b1 = ab[0];
            #1;
            check("tt_run_z", 32'(z1), (i == 1 || i == 2) ? 32'h1 : 32'h0);
            #9;
        end

        a8 = 8'hF0; b8 = 8'h3C;
        #1;
        check("lit_z8", 32'(z8), 32'hCC);
        @(posedge clk); #1;
        check("lit_z8_q",  32'(z8_q),   32'hCC);
        check("lit_par8",  32'(par8_q), 32'h0);
        check("lit_vld8",  32'(vld8_q), 32'h1);
        @(negedge clk);

        // Hold: z follows inputs, registers keep the captured value.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8 = 8'(8'h11 * (i + 1)); b8 = 8'h0F;
            #1;
            check("hold_z8", 32'(z8), 32'(8'(8'h11 * (i + 1)) ^ 8'h0F));
            @(posedge clk); #1;
            check("hold_z8_q", 32'(z8_q),   32'hCC);
            check("hold_par8", 32'(par8_q), 32'h0);
            check("hold_vld8", 32'(vld8_q), 32'h0);
            @(negedge clk);
        end

        for (int n = 0; n < 300; n++) begin
            a1 = 1'($urandom); b1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom);
            en = ($urandom_range(0, 3) != 0);
            #1;
            check("rnd_z1", 32'(z1), 32'(a1 ^ b1));
            check("rnd_z8", 32'(z8), 32'(a8 ^ b8));
            @(negedge clk);
        end

        // Asynchronous reset mid-cycle with z_q=1.
        a1 = 1'b1; b1 = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_z1_q", 32'(z1_q), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_regs_zero("async_rst");
        check("rst_z1", 32'(z1), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef XOR_STATS_EN
        a8 = 8'hFF; b8 = 8'h00; en = 1'b1;
        @(posedge clk); #1;
        check("sat_c1", 32'(dist8_q), 32'd8);
        @(posedge clk); #1;
        check("sat_c2", 32'(dist8_q), 32'd15);
        @(posedge clk); #1;
        check("sat_c3", 32'(dist8_q), 32'd15);
        @(negedge clk);
`endif
        en = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
